// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - memory and decoder-side signal bundle for instruction_fetch
interface instruction_fetch_if;
  logic        run;
  logic [31:0] mem_address;
  logic [31:0] mem_q;
  logic [7:0]  instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halted;

  // Fetch unit side
  modport master (
    input  run,
    input  mem_q,
    input  instr_ready,
    input  redirect,
    input  redirect_pc,
    output mem_address,
    output instr,
    output instr_pc,
    output instr_valid,
    output halted
  );

  // Memory/decoder/control side
  modport slave (
    output run,
    output mem_q,
    output instr_ready,
    output redirect,
    output redirect_pc,
    input  mem_address,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    input  halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and single-entry instruction register; optional halt detect via IFETCH_HALT_EN
module instruction_fetch #(
  parameter logic [7:0] HALT_OPCODE = 8'h00,
  parameter logic [7:0] RESET_PC    = 8'h00
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  instruction_fetch_if.master    bus
);

`ifdef IFETCH_HALT_EN
  typedef enum logic {ST_FETCH = 1'b0, ST_HALTED = 1'b1} state_e;
`else
  typedef enum logic {ST_FETCH = 1'b0} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] instr_pc_q, instr_pc_d;
  logic       valid_q, valid_d;
  logic       load;
`ifdef IFETCH_HALT_EN
  logic       halted_q, halted_d;
`endif

  // Memory read is combinational, so the current pc addresses this cycle's fetch
  assign bus.mem_address = {24'b0, pc_q};
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
`ifdef IFETCH_HALT_EN
  assign bus.halted      = halted_q;
`else
  assign bus.halted      = 1'b0;
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
`endif

  // Only the low byte of the memory word carries instruction data
  logic unused_mem_hi;
  assign unused_mem_hi = ^bus.mem_q[31:8];

  // Next-state: redirect beats everything, then load, then plain accept
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
`ifdef IFETCH_HALT_EN
    halted_d   = halted_q;
`endif
    load = (state_q == ST_FETCH) && bus.run && !bus.redirect &&
           (!valid_q || bus.instr_ready);

    if (bus.redirect) begin
      // Flush the held byte even if the decoder is ready this cycle
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
      state_d = ST_FETCH;
`ifdef IFETCH_HALT_EN
      halted_d = 1'b0;
`endif
    end else if (load) begin
      instr_d    = bus.mem_q[7:0];
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + 8'd1;
`ifdef IFETCH_HALT_EN
      // The halt byte itself is still delivered to the decoder
      if (bus.mem_q[7:0] == HALT_OPCODE) begin
        state_d  = ST_HALTED;
        halted_d = 1'b1;
      end
`endif
    end else if (valid_q && bus.instr_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 8'h00;
      instr_pc_q <= 8'h00;
      valid_q    <= 1'b0;
`ifdef IFETCH_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
`ifdef IFETCH_HALT_EN
      halted_q   <= halted_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
  logic clk;
  logic rst_n;
  logic [7:0] mem [256];
  int n_cmp;
  int n_err;

  instruction_fetch_if ifc ();

  instruction_fetch #(.HALT_OPCODE(8'h00), .RESET_PC(8'h00)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (ifc)
  );

  // Combinational byte-wide memory; upper bits are junk the fetch unit must ignore
  assign ifc.mem_q = {24'hA5C300, mem[ifc.mem_address[7:0]]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_instr, input logic [7:0] e_pc,
                         input logic e_valid, input logic [31:0] e_addr);
    chk({tag, ".instr"},    {24'b0, ifc.instr},       {24'b0, e_instr});
    chk({tag, ".instr_pc"}, {24'b0, ifc.instr_pc},    {24'b0, e_pc});
    chk({tag, ".valid"},    {31'b0, ifc.instr_valid}, {31'b0, e_valid});
    chk({tag, ".addr"},     ifc.mem_address,          e_addr);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
    mem[0] = 8'hE7;
    mem[1] = 8'hE9;
    mem[2] = 8'hC1;
    mem[3] = 8'h00;

    rst_n           = 1'b0;
    ifc.run         = 1'b0;
    ifc.instr_ready = 1'b0;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = 8'h00;
    #2;
    chk_out("reset", 8'h00, 8'h00, 1'b0, 32'h0);
    chk("reset.halted", {31'b0, ifc.halted}, 32'h0);

    @(negedge clk);
    rst_n           = 1'b1;
    ifc.run         = 1'b1;
    ifc.instr_ready = 1'b1;

    step(); chk_out("fetch0", 8'hE7, 8'h00, 1'b1, 32'h1);
    step(); chk_out("fetch1", 8'hE9, 8'h01, 1'b1, 32'h2);

    ifc.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("stall", 8'hE9, 8'h01, 1'b1, 32'h2);
    end
    ifc.instr_ready = 1'b1;
    step(); chk_out("unstall", 8'hC1, 8'h02, 1'b1, 32'h3);

    ifc.redirect = 1'b1; ifc.redirect_pc = 8'h40;
    step();
    chk("redir40.valid", {31'b0, ifc.instr_valid}, 32'h0);
    chk("redir40.addr", ifc.mem_address, 32'h40);
    ifc.redirect = 1'b0;
    step(); chk_out("redir40.load", 8'h50, 8'h40, 1'b1, 32'h41);

    ifc.redirect = 1'b1; ifc.redirect_pc = 8'hFF;
    step();
    chk("redirFF.valid", {31'b0, ifc.instr_valid}, 32'h0);
    chk("redirFF.addr", ifc.mem_address, 32'hFF);
    ifc.redirect = 1'b0;
    step(); chk_out("wrapFF", 8'h0F, 8'hFF, 1'b1, 32'h0);
    step(); chk_out("wrap00", 8'hE7, 8'h00, 1'b1, 32'h1);

    ifc.run = 1'b0; ifc.instr_ready = 1'b0;
    step(); chk_out("stop.hold", 8'hE7, 8'h00, 1'b1, 32'h1);
    ifc.instr_ready = 1'b1;
    step(); chk_out("stop.accept", 8'hE7, 8'h00, 1'b0, 32'h1);
    ifc.run = 1'b1;
    step(); chk_out("resume1", 8'hE9, 8'h01, 1'b1, 32'h2);
    step(); chk_out("resume2", 8'hC1, 8'h02, 1'b1, 32'h3);
    step(); chk_out("op00", 8'h00, 8'h03, 1'b1, 32'h4);
`ifdef IFETCH_HALT_EN
    chk("op00.halted", {31'b0, ifc.halted}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt.valid", {31'b0, ifc.instr_valid}, 32'h0);
      chk("halt.addr", ifc.mem_address, 32'h4);
      chk("halt.halted", {31'b0, ifc.halted}, 32'h1);
    end
`else
    chk("op00.halted", {31'b0, ifc.halted}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("nohalt", 8'(8'h14 + i), 8'(8'h04 + i), 1'b1, 32'(5 + i));
      chk("nohalt.halted", {31'b0, ifc.halted}, 32'h0);
    end
`endif

    ifc.redirect = 1'b1; ifc.redirect_pc = 8'h00;
    step();
    chk("redir0.valid", {31'b0, ifc.instr_valid}, 32'h0);
    chk("redir0.addr", ifc.mem_address, 32'h0);
    chk("redir0.halted", {31'b0, ifc.halted}, 32'h0);
    ifc.redirect = 1'b0;
    step(); chk_out("refetch", 8'hE7, 8'h00, 1'b1, 32'h1);

    #1 rst_n = 1'b0;
    #1;
    chk_out("midreset", 8'h00, 8'h00, 1'b0, 32'h0);
    chk("midreset.halted", {31'b0, ifc.halted}, 32'h0);
    #1 rst_n = 1'b1;
    step(); chk_out("postreset", 8'hE7, 8'h00, 1'b1, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
